// File: rtl/rx_packet_deframer_if.sv
// Byte-in / sample-out bundle for the receive packet deframer.
// Latency: none (signal bundle only); PKT_STATS_EN adds the packet counters.
// Backpressure: sample_ready throttles the sample side; the byte side has none.
interface rx_packet_deframer_if;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
    logic        next_key_en;
    logic        sync_en;
    logic [31:0] sync_state_out;
    logic        pkt_error;
    logic        rx_overrun;
    logic        busy;
`ifdef PKT_STATS_EN
    logic [15:0] good_pkt_count;
    logic [15:0] bad_pkt_count;

    modport slave (
        input  rx_byte, rx_byte_valid, sample_ready,
        output sample_out, sample_valid, next_key_en, sync_en, sync_state_out,
        output pkt_error, rx_overrun, busy, good_pkt_count, bad_pkt_count
    );
    modport master (
        output rx_byte, rx_byte_valid, sample_ready,
        input  sample_out, sample_valid, next_key_en, sync_en, sync_state_out,
        input  pkt_error, rx_overrun, busy, good_pkt_count, bad_pkt_count
    );
`else
    modport slave (
        input  rx_byte, rx_byte_valid, sample_ready,
        output sample_out, sample_valid, next_key_en, sync_en, sync_state_out,
        output pkt_error, rx_overrun, busy
    );
    modport master (
        output rx_byte, rx_byte_valid, sample_ready,
        input  sample_out, sample_valid, next_key_en, sync_en, sync_state_out,
        input  pkt_error, rx_overrun, busy
    );
`endif
endinterface

// File: rtl/rx_packet_deframer.sv
// Parses SYNC/AUDIO packets from the radio byte stream, buffers audio until the checksum verifies. Optional PKT_STATS_EN adds good/bad packet counters.
// Latency: first sample_valid / sync_en the cycle after the CHK byte is accepted.
// Backpressure: samples wait on sample_ready; bytes arriving while draining are dropped and flagged by rx_overrun.
module rx_packet_deframer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_SAMPLES    = 8,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rx_packet_deframer_if.slave  bus
);
    localparam logic [7:0] TYPE_SYNC  = 8'h01;
    localparam logic [7:0] TYPE_AUDIO = 8'h02;
    localparam int IDX_W = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1;
    localparam int LEN_W = $clog2(MAX_SAMPLES + 1);
    localparam int CNT_W = $clog2(2 * MAX_SAMPLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_HUNT, S_TYPE, S_LEN, S_SYNC_PL, S_AUDIO_PL, S_CHK, S_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_xor;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_wr_idx;
    logic [LEN_W-1:0]   r_rd_idx;
    logic [7:0]         r_hi_byte;
    logic [31:0]        r_shadow;
    logic               r_is_audio;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [15:0]        r_buf [MAX_SAMPLES];
    logic [15:0]        r_sample_out;
    logic               r_sample_valid;
    logic               r_sync_en;
    logic [31:0]        r_sync_state;
    logic               r_pkt_error;
    logic               r_rx_overrun;
    logic               r_busy;

    logic               w_err_nxt;
    logic               w_sync_nxt;
    logic               w_ovr_nxt;
    logic               w_active;
    logic               w_timeout;
    logic               w_len_ok;
    logic [CNT_W-1:0]   w_pl_end;
    logic [LEN_W-1:0]   w_rd_nxt;
    logic               w_rd_last;
    logic               w_accept;

    // Timeout only applies while a packet is partially received.
    assign w_active  = (r_state == S_TYPE) || (r_state == S_LEN) || (r_state == S_SYNC_PL) ||
                       (r_state == S_AUDIO_PL) || (r_state == S_CHK);
    assign w_timeout = w_active && !bus.rx_byte_valid &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_len_ok  = (bus.rx_byte != 8'd0) && (bus.rx_byte <= 8'(MAX_SAMPLES));
    assign w_pl_end  = (CNT_W'(r_len) << 1) - CNT_W'(1);
    assign w_rd_nxt  = r_rd_idx + LEN_W'(1);
    assign w_rd_last = (w_rd_nxt == r_len);
    assign w_accept  = r_sample_valid && bus.sample_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_HUNT;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode and one-cycle event requests.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_sync_nxt  = 1'b0;
        w_ovr_nxt   = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (bus.rx_byte_valid && (bus.rx_byte == SYNC_BYTE)) w_state_nxt = S_TYPE;
            end
            S_TYPE: begin
                if (bus.rx_byte_valid) begin
                    if (bus.rx_byte == TYPE_SYNC)       w_state_nxt = S_SYNC_PL;
                    else if (bus.rx_byte == TYPE_AUDIO) w_state_nxt = S_LEN;
                    else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_HUNT;
                    end
                end
            end
            S_LEN: begin
                if (bus.rx_byte_valid) begin
                    if (w_len_ok) w_state_nxt = S_AUDIO_PL;
                    else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_HUNT;
                    end
                end
            end
            S_SYNC_PL: begin
                if (bus.rx_byte_valid && (r_byte_cnt == CNT_W'(3))) w_state_nxt = S_CHK;
            end
            S_AUDIO_PL: begin
                if (bus.rx_byte_valid && (r_byte_cnt == w_pl_end)) w_state_nxt = S_CHK;
            end
            S_CHK: begin
                if (bus.rx_byte_valid) begin
                    if (bus.rx_byte == r_xor) begin
                        if (r_is_audio) w_state_nxt = S_DRAIN;
                        else begin
                            w_sync_nxt  = 1'b1;
                            w_state_nxt = S_HUNT;
                        end
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_HUNT;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.rx_byte_valid) w_ovr_nxt = 1'b1;
                if (w_accept && w_rd_last) w_state_nxt = S_HUNT;
            end
            default: w_state_nxt = S_HUNT;
        endcase
        if (w_timeout) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_HUNT;
        end
    end

    // Sample storage; written on the low byte of each sample pair.
    always_ff @(posedge clk) begin
        if ((r_state == S_AUDIO_PL) && bus.rx_byte_valid && r_byte_cnt[0])
            r_buf[r_wr_idx[IDX_W-1:0]] <= {r_hi_byte, bus.rx_byte};
    end

    // Parser datapath, drain pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xor          <= '0;
            r_byte_cnt     <= '0;
            r_len          <= '0;
            r_wr_idx       <= '0;
            r_rd_idx       <= '0;
            r_hi_byte      <= '0;
            r_shadow       <= '0;
            r_is_audio     <= 1'b0;
            r_tmo_cnt      <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_sync_en      <= 1'b0;
            r_sync_state   <= '0;
            r_pkt_error    <= 1'b0;
            r_rx_overrun   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_pkt_error  <= w_err_nxt;
            r_sync_en    <= w_sync_nxt;
            r_rx_overrun <= w_ovr_nxt;
            r_busy       <= (w_state_nxt != S_HUNT);
            if (bus.rx_byte_valid || !w_active) r_tmo_cnt <= '0;
            else                                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            case (r_state)
                S_HUNT: begin
                    if (bus.rx_byte_valid && (bus.rx_byte == SYNC_BYTE)) begin
                        r_xor      <= '0;
                        r_byte_cnt <= '0;
                        r_wr_idx   <= '0;
                        r_shadow   <= '0;
                    end
                end
                S_TYPE: begin
                    if (bus.rx_byte_valid) begin
                        r_xor      <= r_xor ^ bus.rx_byte;
                        r_is_audio <= (bus.rx_byte == TYPE_AUDIO);
                    end
                end
                S_LEN: begin
                    if (bus.rx_byte_valid) begin
                        r_xor <= r_xor ^ bus.rx_byte;
                        r_len <= bus.rx_byte[LEN_W-1:0];
                    end
                end
                S_SYNC_PL: begin
                    if (bus.rx_byte_valid) begin
                        r_xor      <= r_xor ^ bus.rx_byte;
                        r_shadow   <= {r_shadow[23:0], bus.rx_byte};
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                    end
                end
                S_AUDIO_PL: begin
                    if (bus.rx_byte_valid) begin
                        r_xor      <= r_xor ^ bus.rx_byte;
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        if (!r_byte_cnt[0]) r_hi_byte <= bus.rx_byte;
                        else                r_wr_idx  <= r_wr_idx + LEN_W'(1);
                    end
                end
                S_CHK: begin
                    if (bus.rx_byte_valid) begin
                        if (bus.rx_byte == r_xor) begin
                            if (r_is_audio) begin
                                r_rd_idx       <= '0;
                                r_sample_out   <= r_buf[0];
                                r_sample_valid <= 1'b1;
                            end else begin
                                r_sync_state <= r_shadow;
                            end
                        end else begin
                            // Bad packet: throw away anything partially assembled.
                            r_shadow <= '0;
                            r_wr_idx <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_accept) begin
                        if (w_rd_last) begin
                            r_sample_valid <= 1'b0;
                            r_rd_idx       <= '0;
                        end else begin
                            r_rd_idx     <= w_rd_nxt;
                            r_sample_out <= r_buf[w_rd_nxt[IDX_W-1:0]];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sample_out     = r_sample_out;
    assign bus.sample_valid   = r_sample_valid;
    assign bus.next_key_en    = w_accept;
    assign bus.sync_en        = r_sync_en;
    assign bus.sync_state_out = r_sync_state;
    assign bus.pkt_error      = r_pkt_error;
    assign bus.rx_overrun     = r_rx_overrun;
    assign bus.busy           = r_busy;

`ifdef PKT_STATS_EN
    logic        w_pkt_good;
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    assign w_pkt_good = (r_state == S_CHK) && bus.rx_byte_valid && (bus.rx_byte == r_xor);

    // Saturating good/bad packet counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            if (w_pkt_good && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
            if (w_err_nxt && (r_bad_cnt != 16'hFFFF))   r_bad_cnt  <= r_bad_cnt + 16'd1;
        end
    end

    assign bus.good_pkt_count = r_good_cnt;
    assign bus.bad_pkt_count  = r_bad_cnt;
`endif
endmodule

// File: tb/tb_rx_packet_deframer.sv
// Scoreboard bench for rx_packet_deframer: driver pushes expected samples/sync
// states, a negedge monitor pops and compares whenever the DUT presents them.
module tb_rx_packet_deframer;
    localparam int TMO  = 1024;
    localparam int MAXS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rx_packet_deframer_if bus();

    rx_packet_deframer #(
        .SYNC_BYTE(8'hA5), .MAX_SAMPLES(MAXS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;
    int ovr_seen = 0;
    logic [15:0] exp_smp_q[$];
    logic [31:0] exp_sync_q[$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_out   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.sample_valid && bus.sample_ready) begin
                if (exp_smp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_sample actual=%0h expected=none", bus.sample_out);
                end else begin
                    check("sample_out", {16'h0, bus.sample_out}, {16'h0, exp_smp_q.pop_front()});
                end
                check("next_key_en", {31'h0, bus.next_key_en}, 32'd1);
            end else if (bus.next_key_en) begin
                checks++; failures++;
                $display("FAIL spurious_next_key_en actual=1 expected=0");
            end
            if (prev_stall) begin
                check("stall_valid", {31'h0, bus.sample_valid}, 32'd1);
                check("stall_data", {16'h0, bus.sample_out}, {16'h0, prev_out});
            end
            if (bus.sync_en) begin
                if (exp_sync_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_sync_en actual=%0h expected=none", bus.sync_state_out);
                end else begin
                    check("sync_state_on_en", bus.sync_state_out, exp_sync_q.pop_front());
                end
            end
            if (bus.pkt_error)  err_seen++;
            if (bus.rx_overrun) ovr_seen++;
        end
        prev_stall = rst_n && bus.sample_valid && !bus.sample_ready;
        prev_out   = bus.sample_out;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte       = b;
        bus.rx_byte_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_byte_valid = 1'b0;
    endtask

    task automatic send_audio(input logic [7:0] chk);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h02);
        send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h12); send_byte(8'h34);
        send_byte(chk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_smp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        check("drain_done", exp_smp_q.size(), 32'd0);
    endtask

    // Driver: directed packets with hand-computed expectations.
    initial begin
        logic [7:0] pat;
        int n;
        bus.rx_byte       = 8'h00;
        bus.rx_byte_valid = 1'b0;
        bus.sample_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample_valid", {31'h0, bus.sample_valid}, 32'd0);
        check("rst_sync_state", bus.sync_state_out, 32'd0);
        check("rst_busy", {31'h0, bus.busy}, 32'd0);
        check("rst_pulses", {29'h0, bus.pkt_error, bus.sync_en, bus.rx_overrun}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: SYNC packet, checksum 01^12^34^56^78 = 09
        exp_sync_q.push_back(32'h12345678);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h09);
        idle(4);
        check("s1_sync_state", bus.sync_state_out, 32'h12345678);
        check("s1_sync_consumed", exp_sync_q.size(), 32'd0);
        check("s1_no_error", err_seen, 32'd0);

        // 2a: AUDIO packet, checksum 02^02^BE^EF^12^34 = 77, ready held high
        bus.sample_ready = 1'b1;
        exp_smp_q.push_back(16'hBEEF); exp_smp_q.push_back(16'h1234);
        send_audio(8'h77);
        check("s2_first_valid", {31'h0, bus.sample_valid}, 32'd1);
        check("s2_first_data", {16'h0, bus.sample_out}, 32'h0000BEEF);
        idle(1);
        check("s2_second_data", {16'h0, bus.sample_out}, 32'h00001234);
        idle(1);
        check("s2_valid_drops", {31'h0, bus.sample_valid}, 32'd0);
        check("s2_hunt", {31'h0, bus.busy}, 32'd0);
        wait_drain();

        // 2b: same packet, ready toggled; monitor checks stall stability
        bus.sample_ready = 1'b0;
        exp_smp_q.push_back(16'hBEEF); exp_smp_q.push_back(16'h1234);
        send_audio(8'h77);
        pat = 8'b0010_0100;
        for (int i = 0; i < 8; i++) begin
            bus.sample_ready = pat[i];
            @(posedge clk); #1;
        end
        bus.sample_ready = 1'b0;
        wait_drain();
        check("s2b_hunt", {31'h0, bus.busy}, 32'd0);

        // 3: bad checksum
        bus.sample_ready = 1'b1;
        send_audio(8'h76);
        idle(4);
        check("s3_error", err_seen, 32'd1);
        check("s3_sync_kept", bus.sync_state_out, 32'h12345678);
        check("s3_hunt", {31'h0, bus.busy}, 32'd0);

        // 4: bad lengths, then SYNC CA FE 00 01 (chk 01^CA^FE^00^01 = 34)
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        idle(3);
        check("s4_len0_error", err_seen, 32'd2);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h09);
        idle(3);
        check("s4_len9_error", err_seen, 32'd3);
        exp_sync_q.push_back(32'hCAFE0001);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hCA); send_byte(8'hFE);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h34);
        idle(3);
        check("s4_sync_state", bus.sync_state_out, 32'hCAFE0001);
        check("s4_sync_consumed", exp_sync_q.size(), 32'd0);

        // 5: garbage ignored, then truncated SYNC times out
        send_byte(8'h00); send_byte(8'hFF);
        idle(1);
        check("s5_garbage_hunt", {31'h0, bus.busy}, 32'd0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        check("s5_busy_mid", {31'h0, bus.busy}, 32'd1);
        n = 0;
        while (!bus.pkt_error && n < TMO + 20) begin @(posedge clk); #1; n++; end
        check("s5_timeout_cycles", n, TMO);
        check("s5_timeout_hunt", {31'h0, bus.busy}, 32'd0);
        idle(2);
        check("s5_error", err_seen, 32'd4);
        check("s5_sync_kept", bus.sync_state_out, 32'hCAFE0001);
`ifdef PKT_STATS_EN
        check("stats_good", {16'h0, bus.good_pkt_count}, 32'd4);
        check("stats_bad", {16'h0, bus.bad_pkt_count}, 32'd4);
`endif

        // 6: overrun during DRAIN, then reset mid-DRAIN
        bus.sample_ready = 1'b0;
        exp_smp_q.push_back(16'hBEEF); exp_smp_q.push_back(16'h1234);
        send_audio(8'h77);
        send_byte(8'hA5);
        idle(1);
        check("s6_overrun", ovr_seen, 32'd1);
        check("s6_still_drain", {31'h0, bus.busy}, 32'd1);
        check("s6_data_held", {16'h0, bus.sample_out}, 32'h0000BEEF);
        bus.sample_ready = 1'b1;
        wait_drain();
        idle(2);
        bus.sample_ready = 1'b0;
        check("s6_no_restart", {31'h0, bus.busy}, 32'd0);
        check("s6_no_error", err_seen, 32'd4);
`ifdef PKT_STATS_EN
        check("stats_good6", {16'h0, bus.good_pkt_count}, 32'd5);
`endif
        send_audio(8'h77);
        idle(2);
        check("s6_pre_rst_valid", {31'h0, bus.sample_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("s6_rst_valid", {31'h0, bus.sample_valid}, 32'd0);
        check("s6_rst_busy", {31'h0, bus.busy}, 32'd0);
        check("s6_rst_sync", bus.sync_state_out, 32'd0);
`ifdef PKT_STATS_EN
        check("stats_rst", {bus.good_pkt_count, bus.bad_pkt_count}, 32'd0);
`endif
        rst_n = 1'b1;
        idle(3);
        check("end_samples_empty", exp_smp_q.size(), 32'd0);
        check("end_sync_empty", exp_sync_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_packet_deframer.md
Name: rx_packet_deframer

Overview:
Receive-side counterpart of the push-to-talk packet path. It parses the byte stream delivered by the SPI controller from the radio, hunts for the sync byte, and decodes two packet types: SYNC, which carries the 32-bit key-generator state, and AUDIO, which carries 1..MAX_SAMPLES encrypted 16-bit samples. Audio samples are buffered until the packet checksum verifies, then drained to the decrypt block over a valid/ready handshake. Each consumed sample advances the key generator.

Parameters:
SYNC_BYTE, 8'hA5, start-of-packet marker
MAX_SAMPLES, 8, sample buffer depth; maximum AUDIO payload in samples
TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes mid-packet before abort

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
rx_byte  in  8  byte from SPI controller
rx_byte_valid  in  1  rx_byte valid this cycle (single-cycle strobe)
sample_out  out  16  encrypted sample to decrypt block
sample_valid  out  1  sample_out valid
sample_ready  in  1  consumer accepts sample
next_key_en  out  1  advance key generator (sample_valid & sample_ready)
sync_en  out  1  1-cycle pulse: load sync_state_out into key generator
sync_state_out  out  32  last verified sync state, held
pkt_error  out  1  1-cycle pulse on checksum, length or timeout error
rx_overrun  out  1  1-cycle pulse when a byte arrives during DRAIN and is dropped
busy  out  1  high in any state other than HUNT

Behaviour:
- Reset: rst_n sampled low at a clk edge puts the block in HUNT. All outputs go to 0, sync_state_out = 0, buffer pointers = 0, and any partial packet is discarded. Reset mid-DRAIN drops the remaining samples.
- Packet format: SYNC_BYTE, TYPE, [LEN], payload, CHK.
  - TYPE 8'h01 = SYNC. No LEN byte; payload is 4 bytes, MSB first.
  - TYPE 8'h02 = AUDIO. LEN = sample count; payload is 2*LEN bytes, each sample MSB first.
  - CHK = XOR of TYPE, LEN (if present) and all payload bytes.
- States:
  - HUNT: each valid byte is compared with SYNC_BYTE. A match goes to TYPE; anything else is ignored silently.
  - TYPE: 01 -> SYNC_PL; 02 -> LEN; any other value -> pkt_error, HUNT.
  - LEN: 1..MAX_SAMPLES -> AUDIO_PL; 0 or > MAX_SAMPLES -> pkt_error, HUNT.
  - SYNC_PL: shifts 4 bytes into a shadow register, then goes to CHK.
  - AUDIO_PL: assembles byte pairs and writes each sample to the buffer at an incrementing index. After 2*LEN bytes, goes to CHK.
  - CHK: on the next valid byte, compare it with the running XOR.
    - SYNC match: the cycle after the CHK byte, sync_state_out <= shadow and sync_en pulses 1 cycle; then HUNT.
    - AUDIO match: go to DRAIN.
    - Mismatch: pkt_error pulses; buffer and shadow are discarded; sync_state_out is unchanged; then HUNT.
  - DRAIN: sample_valid = 1 with sample_out = buf[rd_idx]. Each cycle with sample_ready = 1, rd_idx increments and next_key_en pulses. After LEN handshakes, sample_valid drops in the same cycle as the last accept, and the state returns to HUNT. A byte arriving in DRAIN is dropped, rx_overrun pulses, and the byte is not treated as SYNC_BYTE.
- sample_out/sample_valid are stable while sample_ready is low (AXI-style: valid does not wait on ready).
- Timeout: in TYPE, LEN, SYNC_PL, AUDIO_PL or CHK, a counter counts cycles without rx_byte_valid and resets on each valid byte. When it reaches TIMEOUT_CYCLES: pkt_error pulses and the state returns to HUNT. DRAIN has no timeout.
- Latency: first sample_valid asserts the cycle after the CHK byte is accepted.
- Running XOR and payload counters are cleared on entry to TYPE.
- Outputs are registered, except next_key_en, which is combinational from sample_valid & sample_ready.

Optional Feature:
PKT_STATS_EN:
- Defined: adds output ports good_pkt_count[15:0] and bad_pkt_count[15:0].
  - good_pkt_count increments on each verified SYNC or AUDIO packet.
  - bad_pkt_count increments on each pkt_error pulse.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. SYNC packet A5 01 12 34 56 78 09 -> sync_en pulses once; sync_state_out = 32'h12345678; pkt_error stays 0.
2. AUDIO packet A5 02 02 BE EF 12 34 77 with sample_ready = 1 -> sample_out 16'hBEEF then 16'h1234 on consecutive cycles, two next_key_en pulses, then HUNT. Repeat with sample_ready toggled 0/1: values hold while stalled.
3. Same AUDIO packet with CHK = 76 -> pkt_error pulses; no sample_valid; sync_state_out unchanged from scenario 1.
4. A5 02 00, then A5 02 09 (MAX_SAMPLES = 8) -> pkt_error on each LEN byte. A following valid SYNC packet still decodes.
5. A5 01 12 34, then silence for TIMEOUT_CYCLES -> pkt_error and busy = 0. Garbage bytes 00 FF before A5 are ignored.
6. During DRAIN with sample_ready = 0, send byte A5 -> rx_overrun pulses and the packet is not restarted. Assert rst_n = 0 mid-DRAIN -> sample_valid = 0 and the block is in HUNT next cycle. With PKT_STATS_EN defined, the counters match the good/bad packets across scenarios 1-5.
